l1_hit_victim: RTL

- L1 data-cache hit/victim stage; directly downstream of the L1 MESI state array.
- Consumes the per-way MESI read at mm2 plus the tag-match vector, and resolves hit, hit way/state and replacement victim, registered into mm3.
- Owns per-set tree-PLRU replacement bits.
- Generates the mm3 state-array write (fill install, silent E->M store upgrade) and forwards its own recent writes to cover the array's read/write timing gap.

---
 rtl/l1_hit_victim.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/l1_hit_victim.sv
// l1_hit_victim: L1 hit/victim resolve (mm2->mm3), tree-PLRU, MESI state write and forwarding.
// Define L1_RANDOM_REPL_EN to replace tree-PLRU with a 16-bit LFSR victim pick.
module l1_hit_victim #(
    parameter  int L1_NUM_SETS = 64,
    parameter  int L1_NUM_WAYS = 4,
    localparam int SETW        = $clog2(L1_NUM_SETS),
    localparam int WAYW        = $clog2(L1_NUM_WAYS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_mm2,
    input  logic [SETW-1:0]             set_addr_mm2,
    input  logic                        is_store_mm2,
    input  logic [L1_NUM_WAYS-1:0]      tag_match_mm2,
    input  logic [L1_NUM_WAYS-1:0][1:0] state_rd_ways_mm2,
    input  logic                        fill_en_mm3,
    input  logic [SETW-1:0]             fill_set_mm3,
    input  logic [WAYW-1:0]             fill_way_mm3,
    input  logic [1:0]                  fill_state_mm3,
    output logic                        valid_mm3,
    output logic                        hit_mm3,
    output logic [WAYW-1:0]             hit_way_mm3,
    output logic [1:0]                  hit_state_mm3,
    output logic                        upg_req_mm3,
    output logic [WAYW-1:0]             victim_way_mm3,
    output logic                        victim_dirty_mm3,
    output logic                        state_wr_en_mm3,
    output logic [SETW-1:0]             state_wr_set_mm3,
    output logic [WAYW-1:0]             state_wr_way_mm3,
    output logic [1:0]                  state_wr_state_mm3
);
    localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;

    logic [SETW-1:0]             set_q;
    logic                        store_q;
    logic                        wr4_en_q;
    logic [SETW-1:0]             wr4_set_q;
    logic [WAYW-1:0]             wr4_way_q;
    logic [1:0]                  wr4_state_q;
    logic [L1_NUM_WAYS-1:0][1:0] eff;
    logic [L1_NUM_WAYS-1:0]      hit_vec;
    logic                        hit_any, inv_any, upg_e;
    logic [WAYW-1:0]             hit_way, inv_way, repl_way, victim_way;

    assign upg_e              = valid_mm3 && hit_mm3 && store_q && hit_state_mm3 == ST_E;
    assign state_wr_en_mm3    = fill_en_mm3 || upg_e;
    assign state_wr_set_mm3   = fill_en_mm3 ? fill_set_mm3 : set_q;
    assign state_wr_way_mm3   = fill_en_mm3 ? fill_way_mm3 : hit_way_mm3;
    assign state_wr_state_mm3 = fill_en_mm3 ? fill_state_mm3 : ST_M;
    // An E->M upgrade that loses to a fill must re-execute, so it is flagged like an S hit.
    assign upg_req_mm3 = valid_mm3 && hit_mm3 && store_q &&
                         (hit_state_mm3 == ST_S || (hit_state_mm3 == ST_E && fill_en_mm3));

    always_comb begin
        eff     = state_rd_ways_mm2;
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        for (int w = 0; w < L1_NUM_WAYS; w++) begin
            if (wr4_en_q && wr4_set_q == set_addr_mm2 && wr4_way_q == WAYW'(w))
                eff[w] = wr4_state_q;
            if (state_wr_en_mm3 && state_wr_set_mm3 == set_addr_mm2 && state_wr_way_mm3 == WAYW'(w))
                eff[w] = state_wr_state_mm3;
            hit_vec[w] = tag_match_mm2[w] && eff[w] != ST_I;
        end
        for (int w = L1_NUM_WAYS - 1; w >= 0; w--) begin
            hit_way = hit_vec[w] ? WAYW'(w) : hit_way;
            inv_way = eff[w] == ST_I ? WAYW'(w) : inv_way;
        end
        hit_any = |hit_vec;
        inv_any = 1'b0;
        for (int w = 0; w < L1_NUM_WAYS; w++) inv_any = inv_any || eff[w] == ST_I;
        victim_way = inv_any ? inv_way : repl_way;
    end

`ifdef L1_RANDOM_REPL_EN
    logic [15:0] lfsr_q;
    assign repl_way = lfsr_q[WAYW-1:0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'h0001;
        else if (valid_mm2) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
`else
    localparam int NB = L1_NUM_WAYS - 1;
    // Heap-ordered tree: node n lives at bit n-1; a bit of 1 points the victim to the right subtree.
    function automatic logic [NB-1:0] plru_touch(input logic [NB-1:0] b, input logic [WAYW-1:0] way);
        int n;
        plru_touch = b;
        n = 1;
        for (int l = WAYW - 1; l >= 0; l--) begin
            plru_touch[n-1] = ~way[l];
            n = 2 * n + (way[l] ? 1 : 0);
        end
    endfunction

    function automatic logic [WAYW-1:0] plru_victim(input logic [NB-1:0] b);
        int n;
        plru_victim = '0;
        n = 1;
        for (int l = WAYW - 1; l >= 0; l--) begin
            plru_victim[l] = b[n-1];
            n = 2 * n + (b[n-1] ? 1 : 0);
        end
    endfunction

    logic [NB-1:0] plru_q [L1_NUM_SETS];
    logic [NB-1:0] plru_hit_d, plru_fill_d, plru_rd;
    logic          hit_touch;

    assign hit_touch   = valid_mm3 && hit_mm3;
    assign plru_hit_d  = plru_touch(plru_q[set_q], hit_way_mm3);
    assign plru_fill_d = plru_touch((hit_touch && set_q == fill_set_mm3) ? plru_hit_d : plru_q[fill_set_mm3],
                                    fill_way_mm3);
    assign plru_rd     = (fill_en_mm3 && fill_set_mm3 == set_addr_mm2) ? plru_fill_d :
                         (hit_touch && set_q == set_addr_mm2) ? plru_hit_d : plru_q[set_addr_mm2];
    assign repl_way    = plru_victim(plru_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < L1_NUM_SETS; s++) plru_q[s] <= '0;
        end else begin
            if (hit_touch) plru_q[set_q] <= plru_hit_d;
            if (fill_en_mm3) plru_q[fill_set_mm3] <= plru_fill_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_mm3        <= 1'b0;
            hit_mm3          <= 1'b0;
            hit_way_mm3      <= '0;
            hit_state_mm3    <= ST_I;
            victim_way_mm3   <= '0;
            victim_dirty_mm3 <= 1'b0;
            set_q            <= '0;
            store_q          <= 1'b0;
            wr4_en_q         <= 1'b0;
            wr4_set_q        <= '0;
            wr4_way_q        <= '0;
            wr4_state_q      <= ST_I;
        end else begin
            valid_mm3        <= valid_mm2;
            hit_mm3          <= valid_mm2 && hit_any;
            hit_way_mm3      <= hit_way;
            hit_state_mm3    <= eff[hit_way];
            victim_way_mm3   <= victim_way;
            victim_dirty_mm3 <= eff[victim_way] == ST_M;
            set_q            <= set_addr_mm2;
            store_q          <= is_store_mm2;
            wr4_en_q         <= state_wr_en_mm3;
            wr4_set_q        <= state_wr_set_mm3;
            wr4_way_q        <= state_wr_way_mm3;
            wr4_state_q      <= state_wr_state_mm3;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && valid_mm2) assert ($onehot0(hit_vec)) else $error("l1_hit_victim: multiple hit ways");
    end
`endif
endmodule
